// File: rtl/iommu_reg_arbiter.sv
// iommu_reg_arbiter
//   Round-robin arbiter that shares the IOMMU register-map port between
//   N_REQ requesters (AXI programming path, debug path, HW-initiated).
//   Only one access is outstanding at a time. The granted access is held
//   until the register map answers. A watchdog forces an error completion
//   if no answer arrives within TIMEOUT busy cycles.
//
// Ports
//   clk_i, rst_i      rising-edge clock, asynchronous active-high reset
//   req_valid_i       per-requester access valid, held until req_ready_o
//   req_write_i       per-requester direction (1 = write)
//   req_addr_i        per-requester address, packed N_REQ*ADDR_WIDTH
//   req_wdata_i       per-requester write data, packed N_REQ*DATA_WIDTH
//   req_wstrb_i       per-requester byte strobes, packed N_REQ*DATA_WIDTH/8
//   req_ready_o       one-cycle completion pulse to the granted requester
//   req_rdata_o       read data, non-zero only with req_ready_o
//   req_error_o       error flag, non-zero only with req_ready_o
//   reg_valid_o       downstream access valid
//   reg_write_o       downstream direction
//   reg_addr_o        downstream address
//   reg_wdata_o       downstream write data
//   reg_wstrb_o       downstream byte strobes
//   reg_ready_i       downstream completion
//   reg_rdata_i       downstream read data
//   reg_error_i       downstream error
//   timeout_o         one-cycle pulse when the watchdog ends an access

module iommu_reg_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ-1:0]                  req_write_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]       req_wdata_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [DATA_WIDTH-1:0]             req_rdata_o,
  output logic                              req_error_o,

  output logic                              reg_valid_o,
  output logic                              reg_write_o,
  output logic [ADDR_WIDTH-1:0]             reg_addr_o,
  output logic [DATA_WIDTH-1:0]             reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           reg_wstrb_o,
  input  logic                              reg_ready_i,
  input  logic [DATA_WIDTH-1:0]             reg_rdata_i,
  input  logic                              reg_error_i,

  output logic                              timeout_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter must be able to hold TIMEOUT itself: that value marks the
  // forced-completion cycle that follows the last waiting cycle.
  localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } access_t;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q,   ptr_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  access_t              acc_q,   acc_d;

  logic                 sel_found;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [IDX_WIDTH-1:0] cand;
  access_t              sel_acc;
  logic [IDX_WIDTH-1:0] ptr_next;
  logic                 wd_fired;

  // Round-robin search: first valid requester at or above ptr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_WIDTH'((32'(ptr_q) + k) % N_REQ);
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Payload of the requester chosen by the search above.
  always_comb begin
    sel_acc.write = req_write_i[sel_idx];
    sel_acc.addr  = req_addr_i[32'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_acc.wdata = req_wdata_i[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
    sel_acc.wstrb = req_wstrb_i[32'(sel_idx) * STRB_WIDTH +: STRB_WIDTH];
  end

  // Pointer moves past the requester that just completed.
  assign ptr_next = (grant_q == IDX_WIDTH'(N_REQ - 1)) ? '0 : grant_q + IDX_WIDTH'(1);

  // Counter at TIMEOUT means every waiting cycle has been spent.
  assign wd_fired = (cnt_q == CNT_WIDTH'(TIMEOUT));

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    reg_valid_o = 1'b0;
    req_ready_o = '0;
    req_rdata_o = '0;
    req_error_o = 1'b0;
    timeout_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          acc_d   = sel_acc;
          grant_d = sel_idx;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (wd_fired) begin
          // Forced completion: downstream is released, a late answer is ignored.
          req_ready_o[grant_q] = 1'b1;
          req_error_o          = 1'b1;
          timeout_o            = 1'b1;
          ptr_d                = ptr_next;
          state_d              = ST_IDLE;
        end else begin
          reg_valid_o = 1'b1;
          if (reg_ready_i) begin
            req_ready_o[grant_q] = 1'b1;
            req_rdata_o          = reg_rdata_i;
            req_error_o          = reg_error_i;
            ptr_d                = ptr_next;
            state_d              = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and held-access registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign reg_write_o = acc_q.write;
  assign reg_addr_o  = acc_q.addr;
  assign reg_wdata_o = acc_q.wdata;
  assign reg_wstrb_o = acc_q.wstrb;

endmodule

// File: tb/tb_iommu_reg_arbiter.sv
// Self-checking bench for iommu_reg_arbiter: directed scenarios followed by
// randomized rounds. Expected responses are queued when a request is issued
// and consumed by an independent monitor when the DUT completes an access.
module tb_iommu_reg_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_write_i;
  logic [N*AW-1:0]  req_addr_i;
  logic [N*DW-1:0]  req_wdata_i;
  logic [N*SW-1:0]  req_wstrb_i;
  logic [N-1:0]     req_ready_o;
  logic [DW-1:0]    req_rdata_o;
  logic             req_error_o;
  logic             reg_valid_o;
  logic             reg_write_o;
  logic [AW-1:0]    reg_addr_o;
  logic [DW-1:0]    reg_wdata_o;
  logic [SW-1:0]    reg_wstrb_o;
  logic             reg_ready_i;
  logic [DW-1:0]    reg_rdata_i;
  logic             reg_error_i;
  logic             timeout_o;

  iommu_reg_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o), .req_error_o(req_error_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            grant;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    bit            err;
    bit            tmo;
    int            nvalid;
  } exp_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   errors;
  int   checks;
  int   model_ptr;

  logic [N-1:0]  vmask;
  bit            wr_a    [N];
  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [SW-1:0] wstrb_a [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arbitration: first requester at or above ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 0; k < int'(N); k++) begin
      int idx = (ptr + k) % int'(N);
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < int'(N); i++) begin
      req_valid_i[i]            = vmask[i];
      req_write_i[i]            = wr_a[i];
      req_addr_i[i*AW +: AW]    = addr_a[i];
      req_wdata_i[i*DW +: DW]   = wdata_a[i];
      req_wstrb_i[i*SW +: SW]   = wstrb_a[i];
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr_a[i] = w; addr_a[i] = a; wdata_a[i] = d; wstrb_a[i] = s;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom));
  endtask

  // Changes on inputs the DUT must ignore while an access is in flight.
  task automatic perturb();
    for (int i = 0; i < int'(N); i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rand_req(i);
        vmask[i] = 1'($urandom_range(0, 1));
      end
    end
    drive_bus();
  endtask

  // One arbitration round. mode: 0 quiet, 1 perturb others, 2 winner drops valid.
  task automatic do_round(input logic [N-1:0] vm, input int lat,
                          input logic [DW-1:0] rd, input bit er, input int mode);
    exp_t e;
    rsp_t r;
    int   w;
    bit   done;
    @(negedge clk);
    vmask = vm;
    drive_bus();
    if (vm == '0) begin
      repeat (2) begin
        @(negedge clk);
        check("idle_no_valid", reg_valid_o, 1'b0);
      end
      return;
    end
    w        = rr_pick(model_ptr, vm);
    e.grant  = w;
    e.wr     = wr_a[w];
    e.addr   = addr_a[w];
    e.wdata  = wdata_a[w];
    e.wstrb  = wstrb_a[w];
    e.tmo    = (lat >= int'(TO));
    e.rdata  = e.tmo ? '0 : rd;
    e.err    = e.tmo ? 1'b1 : er;
    e.nvalid = e.tmo ? int'(TO) : lat + 1;
    exp_q.push_back(e);
    r.lat = lat; r.rdata = rd; r.err = er;
    rsp_q.push_back(r);
    model_ptr = (w + 1) % int'(N);

    @(negedge clk);
    check("req_latency", reg_valid_o, 1'b1);
    if (mode == 2) begin
      vmask[w] = 1'b0;
      drive_bus();
    end
    done = 1'b0;
    for (int k = 0; k < int'(TO) + 4 && !done; k++) begin
      if (req_ready_o != '0) done = 1'b1;
      else begin
        if (mode == 1) perturb();
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: no req_ready_o within %0d cycles, expected grant %0d", TO + 4, w);
    end
  endtask

  // Downstream register-map model: answers after a planned number of cycles.
  initial begin : responder
    int   cnt;
    bit   active;
    bit   answered;
    rsp_t cur;
    cnt = 0; active = 1'b0; answered = 1'b0;
    cur.lat = 0; cur.rdata = '0; cur.err = 1'b0;
    reg_ready_i = 1'b0; reg_rdata_i = '0; reg_error_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        active = 1'b0; reg_ready_i = 1'b0; reg_error_i = 1'b0;
      end else if (reg_valid_o) begin
        if (!active) begin
          active = 1'b1; answered = 1'b0; cnt = 0;
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else begin cur.lat = 1000; cur.rdata = '0; cur.err = 1'b0; end
        end
        if (cnt == cur.lat) begin
          reg_ready_i = 1'b1; reg_rdata_i = cur.rdata; reg_error_i = cur.err;
          answered = 1'b1;
        end else begin
          reg_ready_i = 1'b0; reg_rdata_i = DW'($urandom); reg_error_i = 1'($urandom_range(0, 1));
        end
        cnt++;
      end else if (active && !answered) begin
        // Watchdog completion cycle: stay quiet.
        active = 1'b0; reg_ready_i = 1'b0; reg_error_i = 1'b0;
      end else begin
        // Idle: stray answers that must be ignored.
        active = 1'b0;
        reg_ready_i = 1'($urandom_range(0, 1));
        reg_rdata_i = DW'($urandom);
        reg_error_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: checks held payload while valid and pops on every completion.
  initial begin : monitor
    int           vcnt;
    exp_t         e;
    logic [N-1:0] oh;
    vcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) vcnt = 0;
      else begin
        if (reg_valid_o) begin
          vcnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: reg_valid_o=1 with no access pending at %0t", $time);
          end else begin
            e = exp_q[0];
            check("reg_payload", {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o},
                  {e.wr, e.addr, e.wdata, e.wstrb});
          end
        end
        if (req_ready_o != '0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: req_ready_o=%b with no access pending at %0t", req_ready_o, $time);
          end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.grant] = 1'b1;
            check("grant",        req_ready_o, oh);
            check("rdata",        req_rdata_o, e.rdata);
            check("error",        req_error_o, e.err);
            check("timeout",      timeout_o,   e.tmo);
            check("valid_cycles", vcnt,        e.nvalid);
          end
          vcnt = 0;
        end else begin
          check("idle_resp_zero", {timeout_o, req_error_o, req_rdata_o}, '0);
        end
      end
    end
  end

  initial begin : stimulus
    int   lat;
    int   sel;
    int   w;
    exp_t e;
    rsp_t r;
    errors = 0; checks = 0; model_ptr = 0;
    rst = 1'b1;
    vmask = '0;
    for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, '0, '0, '0);
    drive_bus();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req_ready_o, req_rdata_o, req_error_o, reg_valid_o, reg_write_o,
           reg_addr_o, reg_wdata_o, reg_wstrb_o, timeout_o}, '0);
    rst = 1'b0;

    // Single read from requester 0, answered in the first busy cycle.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    do_round(3'b001, 0, 32'hDEADBEEF, 1'b0, 0);

    // Write with partial strobes from requester 1, answer delayed 5 cycles.
    set_req(1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    do_round(3'b010, 5, DW'($urandom), 1'b0, 0);

    // Contention between requesters 0 and 1: grants must alternate.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, AW'(32'h100 + k), DW'(32'hA000 + k), 4'hF);
      set_req(1, 1'b0, AW'(32'h200 + k), DW'(32'hB000 + k), 4'h1);
      do_round(3'b011, 0, DW'($urandom), 1'b0, 0);
    end

    // Watchdog expiry, then answer on the last possible cycle.
    rand_req(2);
    do_round(3'b100, int'(TO) + 3, DW'($urandom), 1'b0, 0);
    rand_req(0);
    do_round(3'b001, int'(TO) - 1, DW'($urandom), 1'b1, 0);

    // Granted requester drops valid mid-access.
    rand_req(1);
    do_round(3'b010, 3, DW'($urandom), 1'b0, 2);

    // Reset in the middle of a busy access (pointer is 2 at this point).
    @(negedge clk);
    rand_req(0);
    vmask = 3'b001;
    drive_bus();
    w = rr_pick(model_ptr, vmask);
    e.grant = w; e.wr = wr_a[w]; e.addr = addr_a[w]; e.wdata = wdata_a[w]; e.wstrb = wstrb_a[w];
    e.rdata = '0; e.err = 1'b0; e.tmo = 1'b0; e.nvalid = 0;
    exp_q.push_back(e);
    r.lat = 1000; r.rdata = '0; r.err = 1'b0;
    rsp_q.push_back(r);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_busy",
          {req_ready_o, req_rdata_o, req_error_o, reg_valid_o, reg_write_o,
           reg_addr_o, reg_wdata_o, reg_wstrb_o, timeout_o}, '0);
    exp_q.delete();
    rsp_q.delete();
    model_ptr = 0;
    vmask = '0;
    drive_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rand_req(1);
    rand_req(2);
    do_round(3'b110, 1, DW'($urandom), 1'b0, 0);

    // Randomized rounds.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < int'(N); i++) rand_req(i);
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       lat = int'($urandom_range(0, 2));
      else if (sel < 8)  lat = int'($urandom_range(3, TO - 1));
      else if (sel == 8) lat = int'(TO) - 1;
      else               lat = int'(TO) + int'($urandom_range(0, 3));
      do_round(N'($urandom_range(0, (1 << N) - 1)), lat, DW'($urandom),
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    vmask = '0;
    drive_bus();
    repeat (4) @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
